// File: rtl/cache_chk_pkg.sv
// Shared types and constants for the L1 miss/refill protocol monitor.
package cache_chk_pkg;

  localparam int unsigned ERR_NUM    = 6;
  localparam int unsigned ERR_CODE_W = 3;

  localparam int unsigned ERR_HIT_MMIO  = 0;
  localparam int unsigned ERR_HIT_MISS  = 1;
  localparam int unsigned ERR_WB_ORDER  = 2;
  localparam int unsigned ERR_TIMEOUT   = 3;
  localparam int unsigned ERR_STATE_SEQ = 4;
  localparam int unsigned ERR_SPURIOUS  = 5;

  typedef logic [ERR_NUM-1:0] err_vec_t;

  typedef enum logic [2:0] {
    CHK_IDLE,
    CHK_WB_REQ,
    CHK_WB_RESP,
    CHK_RD_REQ,
    CHK_RD_RESP
  } chk_state_e;

  // Lowest set error code wins when several fire in the same cycle.
  function automatic logic [ERR_CODE_W-1:0] lowest_err_code(input err_vec_t v);
    lowest_err_code = '0;
    for (int i = ERR_NUM - 1; i >= 0; i--) begin
      if (v[i]) lowest_err_code = ERR_CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/cache_protocol_monitor_if.sv
// Cache stage-3 / memory-port observation bus plus the monitor's result outputs.
interface cache_protocol_monitor_if #(
  parameter int unsigned TAG_WIDTH   = 39,
  parameter int unsigned STATE_WIDTH = 4,
  parameter int unsigned CNT_WIDTH   = 16
);
  import cache_chk_pkg::*;

  logic                   chk_en;
  logic                   cache_hit;
  logic                   miss;
  logic                   mmio;
  logic                   probe;
  logic [1:0]             flush;
  logic                   s3_meta_valid;
  logic                   s3_meta_dirty;
  logic [TAG_WIDTH-1:0]   s3_meta_tag;
  logic [STATE_WIDTH-1:0] s3_state;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_req_is_write;
  logic                   mem_resp_valid;
  logic                   mem_resp_last;

  err_vec_t               err_vec;
  logic                   err_pulse;
  logic [ERR_CODE_W-1:0]  first_err_code;
  logic [TAG_WIDTH-1:0]   first_err_tag;
  logic [CNT_WIDTH-1:0]   miss_count;
  logic [CNT_WIDTH-1:0]   err_count;
  logic                   busy;

  modport master (
    output chk_en, cache_hit, miss, mmio, probe, flush,
           s3_meta_valid, s3_meta_dirty, s3_meta_tag, s3_state,
           mem_req_valid, mem_req_ready, mem_req_is_write,
           mem_resp_valid, mem_resp_last,
    input  err_vec, err_pulse, first_err_code, first_err_tag,
           miss_count, err_count, busy
  );

  modport slave (
    input  chk_en, cache_hit, miss, mmio, probe, flush,
           s3_meta_valid, s3_meta_dirty, s3_meta_tag, s3_state,
           mem_req_valid, mem_req_ready, mem_req_is_write,
           mem_resp_valid, mem_resp_last,
    output err_vec, err_pulse, first_err_code, first_err_tag,
           miss_count, err_count, busy
  );

endinterface

// File: rtl/cache_chk_age_timer.sv
// Open-miss age counter; flags the cycle in which the age reaches MAX_LAT-1.
module cache_chk_age_timer #(
  parameter int unsigned MAX_LAT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_c_o
);

  localparam int unsigned AGE_W = $clog2(MAX_LAT);

  logic [AGE_W-1:0] age_q;
  logic [AGE_W-1:0] age_d;

  assign age_d      = age_q + AGE_W'(1);
  assign expire_c_o = enable_i && (age_d == AGE_W'(MAX_LAT - 1));

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      age_q <= '0;
    end else if (enable_i) begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/cache_protocol_monitor.sv
// Protocol checker for the L1 miss/refill path: qualifier exclusivity plus
// per-miss ordering, state-step, spurious-response and latency tracking.
module cache_protocol_monitor
  import cache_chk_pkg::*;
#(
  parameter int unsigned TAG_WIDTH    = 39,
  parameter int unsigned STATE_WIDTH  = 4,
  parameter int unsigned S3_IDLE      = 0,
  parameter int unsigned S3_READ_REQ  = 1,
  parameter int unsigned S3_READ_WAIT = 2,
  parameter int unsigned MAX_LAT      = 64,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic                     clock,
  input logic                     reset,
  cache_protocol_monitor_if.slave mon_if
);

  if (MAX_LAT < 4) begin : g_bad_max_lat
    $error("cache_protocol_monitor: MAX_LAT must be at least 4");
  end
  if (S3_IDLE == S3_READ_REQ || S3_IDLE == S3_READ_WAIT || S3_READ_REQ == S3_READ_WAIT) begin : g_bad_enc
    $error("cache_protocol_monitor: stage-3 state encodings must be distinct");
  end

  chk_state_e            state_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  oneshot_q;
  logic                  hs_ok_q;
  logic                  busy_q;
  err_vec_t              err_vec_q;
  logic                  err_pulse_q;
  logic [ERR_CODE_W-1:0] first_code_q;
  logic [TAG_WIDTH-1:0]  first_tag_q;
  logic [CNT_WIDTH-1:0]  miss_cnt_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;

  logic     start_c, abort_c, timeout_c, expire_c, to_idle_c;
  logic     req_hs_c, rd_hs_c, resp_last_c;
  err_vec_t det_c, new_err_c;
  logic     flush_unused;

  assign flush_unused = mon_if.flush[0];

  cache_chk_age_timer #(.MAX_LAT(MAX_LAT)) u_age (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (start_c),
    .enable_i   (state_q != CHK_IDLE),
    .expire_c_o (expire_c)
  );

  // Per-cycle violation detection; a flush abort silences the transaction checks.
  always_comb begin
    start_c     = (state_q == CHK_IDLE) && mon_if.miss && !mon_if.mmio &&
                  !mon_if.probe && !mon_if.flush[1];
    abort_c     = (state_q != CHK_IDLE) && mon_if.flush[1];
    timeout_c   = expire_c && !abort_c;
    req_hs_c    = mon_if.mem_req_valid && mon_if.mem_req_ready;
    rd_hs_c     = req_hs_c && !mon_if.mem_req_is_write;
    resp_last_c = mon_if.mem_resp_valid && mon_if.mem_resp_last;
    to_idle_c   = abort_c || timeout_c || ((state_q == CHK_RD_RESP) && resp_last_c);

    det_c                = '0;
    det_c[ERR_HIT_MMIO]  = mon_if.cache_hit && mon_if.mmio;
    det_c[ERR_HIT_MISS]  = mon_if.cache_hit && mon_if.miss;
    det_c[ERR_WB_ORDER]  = (state_q == CHK_WB_REQ) && rd_hs_c && !abort_c;
    det_c[ERR_TIMEOUT]   = timeout_c;
    det_c[ERR_STATE_SEQ] = oneshot_q && !abort_c &&
                           (!hs_ok_q || (mon_if.s3_state != STATE_WIDTH'(S3_READ_WAIT)));
    det_c[ERR_SPURIOUS]  = mon_if.mem_resp_valid && !abort_c &&
                           ((state_q == CHK_IDLE) || (state_q == CHK_WB_REQ) ||
                            (state_q == CHK_RD_REQ));
    new_err_c            = mon_if.chk_en ? det_c : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CHK_IDLE;
      tag_q     <= '0;
      oneshot_q <= 1'b0;
      hs_ok_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      oneshot_q <= 1'b0;
      busy_q    <= start_c ? 1'b1 : (to_idle_c ? 1'b0 : busy_q);
      if (abort_c || timeout_c) begin
        state_q <= CHK_IDLE;
      end else begin
        case (state_q)
          CHK_IDLE: if (start_c) begin
            tag_q   <= mon_if.s3_meta_tag;
            state_q <= (mon_if.s3_meta_valid && mon_if.s3_meta_dirty) ? CHK_WB_REQ : CHK_RD_REQ;
          end
          CHK_WB_REQ: if (req_hs_c) begin
            state_q <= mon_if.mem_req_is_write ? CHK_WB_RESP : CHK_RD_RESP;
          end
          CHK_WB_RESP: if (resp_last_c) state_q <= CHK_RD_REQ;
          // Read handshake arms the next-cycle stage-3 state-step check.
          CHK_RD_REQ: if (rd_hs_c) begin
            state_q   <= CHK_RD_RESP;
            oneshot_q <= 1'b1;
            hs_ok_q   <= (mon_if.s3_state == STATE_WIDTH'(S3_READ_REQ));
          end
          CHK_RD_RESP: if (resp_last_c) state_q <= CHK_IDLE;
          default: state_q <= CHK_IDLE;
        endcase
      end
    end
  end

  // Sticky error capture and saturating statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_vec_q    <= '0;
      err_pulse_q  <= 1'b0;
      first_code_q <= '0;
      first_tag_q  <= '0;
      miss_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      err_pulse_q <= |new_err_c;
      if (|new_err_c) begin
        err_vec_q <= err_vec_q | new_err_c;
        if (err_vec_q == '0) begin
          first_code_q <= lowest_err_code(new_err_c);
          first_tag_q  <= tag_q;
        end
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
      end
      if (start_c && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign mon_if.err_vec        = err_vec_q;
  assign mon_if.err_pulse      = err_pulse_q;
  assign mon_if.first_err_code = first_code_q;
  assign mon_if.first_err_tag  = first_tag_q;
  assign mon_if.miss_count     = miss_cnt_q;
  assign mon_if.err_count      = err_cnt_q;
  assign mon_if.busy           = busy_q;

endmodule

// File: tb/tb_cache_protocol_monitor.sv
// Scoreboard bench for cache_protocol_monitor: directed protocol scenarios with
// hand-computed per-cycle snapshots and expected error-pulse payloads.
module tb_cache_protocol_monitor;
  import cache_chk_pkg::*;

  localparam int unsigned TW = 39;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned ML = 8;

  typedef struct {
    int unsigned   cyc;
    string         name;
    logic [5:0]    vec;
    logic          pulse;
    logic [2:0]    code;
    logic [TW-1:0] tag;
    logic [CW-1:0] ecnt;
    logic [CW-1:0] mcnt;
    logic          busy;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic [5:0]  pulse_q[$];
  exp_t        e;
  logic [5:0]  pv;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  cache_protocol_monitor_if #(.TAG_WIDTH(TW), .STATE_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

  cache_protocol_monitor #(
    .TAG_WIDTH(TW), .STATE_WIDTH(SW), .S3_IDLE(0), .S3_READ_REQ(1),
    .S3_READ_WAIT(2), .MAX_LAT(ML), .CNT_WIDTH(CW)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .mon_if (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.chk_en = 1'b1;        bus.cache_hit = 1'b0;     bus.miss = 1'b0;
    bus.mmio = 1'b0;          bus.probe = 1'b0;         bus.flush = 2'b00;
    bus.s3_meta_valid = 1'b0; bus.s3_meta_dirty = 1'b0; bus.s3_meta_tag = '0;
    bus.s3_state = '0;        bus.mem_req_valid = 1'b0; bus.mem_req_ready = 1'b0;
    bus.mem_req_is_write = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_last = 1'b0;
  endtask

  task automatic expect_at(input int unsigned dly, input string nm, input logic [5:0] v,
                           input logic p, input logic [2:0] c, input logic [TW-1:0] t,
                           input logic [CW-1:0] ec, input logic [CW-1:0] mc, input logic b);
    exp_t x;
    x.cyc = cyc + dly; x.name = nm; x.vec = v; x.pulse = p; x.code = c;
    x.tag = t; x.ecnt = ec; x.mcnt = mc; x.busy = b;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    expect_at(0, "reset", 6'h00, 1'b0, 3'd0, '0, '0, '0, 1'b0);
  endtask

  task automatic rd_hs(input logic [SW-1:0] st);
    bus.mem_req_valid = 1'b1; bus.mem_req_ready = 1'b1;
    bus.mem_req_is_write = 1'b0; bus.s3_state = st;
  endtask

  task automatic resp_last();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_last = 1'b1;
  endtask

  // Monitor: pops the pulse queue on every err_pulse, and snapshot entries by cycle.
  always @(negedge clock) begin
    if (bus.err_pulse === 1'b1) begin
      n_tests++;
      if (pulse_q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_unexpected cyc=%0d got err_vec=%b, required no pulse", cyc, bus.err_vec);
      end else begin
        pv = pulse_q.pop_front();
        if (bus.err_vec !== pv) begin
          n_fail++;
          $display("FAIL pulse_vec cyc=%0d got err_vec=%b, required %b", cyc, bus.err_vec, pv);
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_tests++;
      if (e.cyc != cyc || bus.err_vec !== e.vec || bus.err_pulse !== e.pulse ||
          bus.first_err_code !== e.code || bus.first_err_tag !== e.tag ||
          bus.err_count !== e.ecnt || bus.miss_count !== e.mcnt || bus.busy !== e.busy) begin
        n_fail++;
        $display("FAIL %s cyc=%0d/%0d got vec=%b pulse=%b code=%0d tag=%h ecnt=%0d mcnt=%0d busy=%b required vec=%b pulse=%b code=%0d tag=%h ecnt=%0d mcnt=%0d busy=%b",
                 e.name, cyc, e.cyc, bus.err_vec, bus.err_pulse, bus.first_err_code,
                 bus.first_err_tag, bus.err_count, bus.miss_count, bus.busy,
                 e.vec, e.pulse, e.code, e.tag, e.ecnt, e.mcnt, e.busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no finish, required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    // hit && mmio for one cycle
    do_reset();
    bus.cache_hit = 1'b1; bus.mmio = 1'b1;
    expect_at(1, "hit_mmio", 6'h01, 1'b1, 3'd0, '0, 16'd1, 16'd0, 1'b0);
    pulse_q.push_back(6'h01);
    tick(); idle();
    expect_at(1, "hit_mmio_hold", 6'h01, 1'b0, 3'd0, '0, 16'd1, 16'd0, 1'b0);
    tick(); tick();

    // hit && miss && mmio: two codes, one count, lowest code first
    do_reset();
    bus.cache_hit = 1'b1; bus.miss = 1'b1; bus.mmio = 1'b1;
    expect_at(1, "multi_code", 6'h03, 1'b1, 3'd0, '0, 16'd1, 16'd0, 1'b0);
    pulse_q.push_back(6'h03);
    tick(); idle(); tick();

    // clean dirty-miss transaction
    do_reset();
    bus.miss = 1'b1; bus.s3_meta_valid = 1'b1; bus.s3_meta_dirty = 1'b1; bus.s3_meta_tag = 'h1234;
    expect_at(1, "dm_start", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b1);
    tick(); idle();
    bus.mem_req_valid = 1'b1; bus.mem_req_ready = 1'b1; bus.mem_req_is_write = 1'b1;
    expect_at(1, "dm_wb_req", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b1);
    tick(); idle(); resp_last();
    expect_at(1, "dm_wb_resp", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b1);
    tick(); idle(); rd_hs(4'd1);
    expect_at(1, "dm_rd_req", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b1);
    tick(); idle(); bus.s3_state = 4'd2; resp_last();
    expect_at(1, "dm_done", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b0);
    tick(); idle(); tick();

    // dirty miss whose first handshake is a read
    do_reset();
    bus.miss = 1'b1; bus.s3_meta_valid = 1'b1; bus.s3_meta_dirty = 1'b1; bus.s3_meta_tag = 'h1234;
    expect_at(1, "wo_start", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b1);
    tick(); idle(); rd_hs(4'd1);
    expect_at(1, "wb_order", 6'h04, 1'b1, 3'd2, 'h1234, 16'd1, 16'd1, 1'b1);
    pulse_q.push_back(6'h04);
    tick(); idle(); resp_last();
    expect_at(1, "wo_done", 6'h04, 1'b0, 3'd2, 'h1234, 16'd1, 16'd1, 1'b0);
    tick(); idle(); tick();

    // state step: wrong state after handshake, then wrong state at handshake
    do_reset();
    bus.miss = 1'b1; bus.s3_meta_tag = 'h55;
    expect_at(1, "ss_start", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b1);
    tick(); idle(); rd_hs(4'd1);
    expect_at(1, "ss_hs", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b1);
    tick(); idle(); bus.s3_state = 4'd0;
    expect_at(1, "ss_bad_wait", 6'h10, 1'b1, 3'd4, 'h55, 16'd1, 16'd1, 1'b1);
    pulse_q.push_back(6'h10);
    tick(); idle(); resp_last();
    expect_at(1, "ss_done", 6'h10, 1'b0, 3'd4, 'h55, 16'd1, 16'd1, 1'b0);
    tick(); idle();
    bus.miss = 1'b1; bus.s3_meta_tag = 'h66;
    expect_at(1, "ss2_start", 6'h10, 1'b0, 3'd4, 'h55, 16'd1, 16'd2, 1'b1);
    tick(); idle(); rd_hs(4'd3);
    expect_at(1, "ss2_hs", 6'h10, 1'b0, 3'd4, 'h55, 16'd1, 16'd2, 1'b1);
    tick(); idle(); bus.s3_state = 4'd2;
    expect_at(1, "ss2_bad_req", 6'h10, 1'b1, 3'd4, 'h55, 16'd2, 16'd2, 1'b1);
    pulse_q.push_back(6'h10);
    tick(); idle(); resp_last();
    expect_at(1, "ss2_done", 6'h10, 1'b0, 3'd4, 'h55, 16'd2, 16'd2, 1'b0);
    tick(); idle(); tick();

    // timeout with MAX_LAT=8, then a response while idle
    do_reset();
    bus.miss = 1'b1; bus.s3_meta_tag = 'h77;
    expect_at(1, "to_start", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b1);
    tick(); idle();
    for (int i = 1; i <= 6; i++) begin
      expect_at(1, "to_open", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b1);
      tick();
    end
    expect_at(1, "timeout", 6'h08, 1'b1, 3'd3, 'h77, 16'd1, 16'd1, 1'b0);
    pulse_q.push_back(6'h08);
    tick(); bus.mem_resp_valid = 1'b1;
    expect_at(1, "to_spurious", 6'h28, 1'b1, 3'd3, 'h77, 16'd2, 16'd1, 1'b0);
    pulse_q.push_back(6'h28);
    tick(); idle(); tick();

    // flush abort cancels the one-shot; reset mid-miss; chk_en=0 suppression
    do_reset();
    bus.miss = 1'b1; bus.s3_meta_tag = 'h99;
    expect_at(1, "fl_start", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b1);
    tick(); idle(); rd_hs(4'd1);
    expect_at(1, "fl_hs", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b1);
    tick(); idle(); bus.flush = 2'b10; bus.s3_state = 4'd0;
    expect_at(1, "fl_abort", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b0);
    tick(); idle();
    expect_at(1, "fl_after", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd1, 1'b0);
    tick(); idle();
    bus.miss = 1'b1; bus.s3_meta_valid = 1'b1; bus.s3_meta_dirty = 1'b1; bus.s3_meta_tag = 'habc;
    expect_at(1, "rm_start", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd2, 1'b1);
    tick(); idle();
    reset = 1'b1; bus.mem_resp_valid = 1'b1; bus.cache_hit = 1'b1; bus.mmio = 1'b1;
    expect_at(1, "rm_reset", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd0, 1'b0);
    tick(); idle(); reset = 1'b0;
    bus.chk_en = 1'b0; bus.cache_hit = 1'b1; bus.mmio = 1'b1;
    expect_at(1, "chk_dis", 6'h00, 1'b0, 3'd0, '0, 16'd0, 16'd0, 1'b0);
    tick(); idle(); tick(); tick();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d snapshots pending, required 0", exp_q.size());
    end
    n_tests++;
    if (pulse_q.size() != 0) begin
      n_fail++;
      $display("FAIL pulse_drain got %0d pulses missing, required 0", pulse_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
